// File: rtl/median_arbiter.sv
// ============================================================================
// median_arbiter : round-robin sharing of one MEDIAN filter among NREQ windows
// Rev 1.0
// ============================================================================
`default_nettype none

module median_arbiter #(
   parameter int WIDTH   = 8,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 63
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NREQ-1:0]       REQ,
   output logic [NREQ-1:0]       GNT,
   input  logic [NREQ*WIDTH-1:0] DI,
   input  logic [NREQ-1:0]       DSI,
   output logic [WIDTH-1:0]      DO,
   output logic [NREQ-1:0]       DONE,
   output logic                  ERR,
   output logic                  BUSY,
   output logic [WIDTH-1:0]      M_DI,
   output logic                  M_DSI,
   output logic                  M_NRST,
   input  logic [WIDTH-1:0]      M_DO,
   input  logic                  M_DSO
);

   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ABORT = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [PW-1:0]    ptr, ptr_nx, g, g_nx, pick, cand;
   logic [3:0]       cnt, cnt_nx;
   logic [WDW-1:0]   wdog, wdog_nx, wdog_inc;
   logic [NREQ-1:0]  gnt, gnt_nx, done, done_nx;
   logic [WIDTH-1:0] med, med_nx;
   logic             err, err_nx;
   logic [WIDTH-1:0] di_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign di_arr[i] = DI[i*WIDTH +: WIDTH];
   end

   // Lowest offset from ptr wins, so iterate from the far end down.
   always_comb begin
      pick = ptr;
      cand = ptr;
      for (int k = NREQ; k >= 1; k--) begin
         cand = PW'((int'(ptr) + k) % NREQ);
         if (REQ[cand]) pick = cand;
      end
   end

   assign wdog_inc = (wdog == WDW'(TIMEOUT)) ? wdog : wdog + WDW'(1);

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      g_nx     = g;
      cnt_nx   = cnt;
      wdog_nx  = wdog;
      gnt_nx   = gnt;
      med_nx   = med;
      done_nx  = '0;
      err_nx   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|REQ) begin
               g_nx     = pick;
               gnt_nx   = ONE << pick;
               cnt_nx   = 4'd0;
               state_nx = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (DSI[g]) begin
               cnt_nx = cnt + 4'd1;
               if (cnt == 4'd8) begin
                  wdog_nx  = '0;
                  state_nx = ST_WAIT;
               end
            end else if (cnt != 4'd0) begin
               gnt_nx   = '0;
               err_nx   = 1'b1;
               state_nx = ST_ABORT;
            end else if (!REQ[g]) begin
               gnt_nx   = '0;
               ptr_nx   = g;
               state_nx = ST_IDLE;
            end
         end
         ST_WAIT: begin
            wdog_nx = wdog_inc;
            if (M_DSO) begin
               med_nx   = M_DO;
               done_nx  = ONE << g;
               ptr_nx   = g;
               gnt_nx   = '0;
               state_nx = ST_IDLE;
            end else if (wdog_inc == WDW'(TIMEOUT)) begin
               gnt_nx   = '0;
               err_nx   = 1'b1;
               state_nx = ST_ABORT;
            end
         end
         default: begin
            ptr_nx   = g;
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
         ptr   <= PW'(NREQ - 1);
         g     <= '0;
         cnt   <= '0;
         wdog  <= '0;
         gnt   <= '0;
         med   <= '0;
         done  <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         g     <= g_nx;
         cnt   <= cnt_nx;
         wdog  <= wdog_nx;
         gnt   <= gnt_nx;
         med   <= med_nx;
         done  <= done_nx;
         err   <= err_nx;
      end
   end

   assign GNT    = gnt;
   assign DO     = med;
   assign DONE   = done;
   assign ERR    = err;
   assign BUSY   = (state != ST_IDLE);
   assign M_DI   = (state == ST_LOAD) ? di_arr[g] : '0;
   assign M_DSI  = (state == ST_LOAD) & DSI[g];
   assign M_NRST = !(RST | (state == ST_ABORT));

endmodule

`default_nettype wire
